// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared types for the ID-stage scoreboard controller: FSM state
// encodings and the default pending-counter width.
package id_scoreboard_ctrl_pkg;

    typedef enum logic [1:0] {
        SCB_RUN   = 2'd0,
        SCB_FLUSH = 2'd1,
        SCB_DRAIN = 2'd2
    } scb_state_e;

    localparam int SCB_CNT_W = 2;

endpackage

// File: rtl/id_scoreboard_ctrl_if.sv
// ID-side bundle for the scoreboard controller: decoded operands,
// writeback retire info, redirect, and the issue/stall/flush response.
interface id_scoreboard_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_SEL  = 5
);
    logic                id_valid;
    logic [REG_SEL-1:0]  rs1;
    logic [REG_SEL-1:0]  rs2;
    logic                uses_rs1;
    logic                uses_rs2;
    logic [REG_SEL-1:0]  rd;
    logic                reg_write_out;
    logic                wb_valid;
    logic [REG_SEL-1:0]  wb_rd;
    logic                redirect;
    logic                issue;
    logic                stall;
    logic                flush_id;
    logic [NUM_REGS-1:0] pending_mask;
    logic [1:0]          state_dbg;

    modport master (
        output id_valid, rs1, rs2, uses_rs1, uses_rs2, rd,
        output reg_write_out, wb_valid, wb_rd, redirect,
        input  issue, stall, flush_id, pending_mask, state_dbg
    );

    modport slave (
        input  id_valid, rs1, rs2, uses_rs1, uses_rs2, rd,
        input  reg_write_out, wb_valid, wb_rd, redirect,
        output issue, stall, flush_id, pending_mask, state_dbg
    );
endinterface

// File: rtl/scb_counter_bank.sv
// Per-register pending-write counters, saturating in both directions,
// with a registered nonzero mask. Register 0 never counts.
module scb_counter_bank
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_SEL  = 5,
    parameter int CNT_W    = SCB_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inc_en_i,
    input  logic [REG_SEL-1:0]             inc_sel_i,
    input  logic                           dec_en_i,
    input  logic [REG_SEL-1:0]             dec_sel_i,
    output logic [NUM_REGS-1:0][CNT_W-1:0] cnt_o,
    output logic [NUM_REGS-1:0]            nz_mask_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0]            mask_q, mask_d;

    always_comb begin
        cnt_d  = cnt_q;
        mask_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            // a retire at zero is dropped so an inc in the same cycle still lands
            if (inc_en_i && inc_sel_i == REG_SEL'(i) && cnt_q[i] != CNT_MAX &&
                !(dec_en_i && dec_sel_i == REG_SEL'(i) && cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_en_i && dec_sel_i == REG_SEL'(i) && cnt_q[i] != '0 &&
                         !(inc_en_i && inc_sel_i == REG_SEL'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            mask_d[i] = cnt_d[i] != '0;
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && dec_en_i) begin
            assert (!$isunknown(dec_sel_i) && cnt_q[dec_sel_i] != '0);
        end
    end

    assign cnt_o     = cnt_q;
    assign nz_mask_o = mask_q;

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// ID issue controller: RAW/structural stall on pending writes and a
// multi-cycle flush after redirect. Optional macro: SCB_WB_BYPASS_EN.
module id_scoreboard_ctrl
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_SEL      = 5,
    parameter int CNT_W        = SCB_CNT_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    id_scoreboard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       FL_LOAD = 4'(FLUSH_CYCLES - 1);

    scb_state_e state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic rs1_busy, rs2_busy;
    logic hazard, structural, can_issue;
    logic issue, stall, flush;

    always_comb begin
        rs1_busy = bus.rs1 != '0 && cnt[bus.rs1] != '0;
        rs2_busy = bus.rs2 != '0 && cnt[bus.rs2] != '0;
`ifdef SCB_WB_BYPASS_EN
        // last pending write retiring now: regfile writes before read
        if (cnt[bus.rs1] == CNT_ONE && bus.wb_valid && bus.wb_rd == bus.rs1)
            rs1_busy = 1'b0;
        if (cnt[bus.rs2] == CNT_ONE && bus.wb_valid && bus.wb_rd == bus.rs2)
            rs2_busy = 1'b0;
`endif
        hazard = bus.id_valid &&
                 ((bus.uses_rs1 && rs1_busy) || (bus.uses_rs2 && rs2_busy));
        structural = bus.id_valid && bus.reg_write_out &&
                     bus.rd != '0 && cnt[bus.rd] == CNT_MAX;
        can_issue = bus.id_valid && !hazard && !structural;
    end

    always_comb begin
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            SCB_RUN, SCB_DRAIN: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = SCB_FLUSH;
                        fcnt_d  = FL_LOAD;
                    end else begin
                        state_d = SCB_RUN;
                    end
                end else if (state_q == SCB_RUN) begin
                    issue = can_issue;
                    stall = bus.id_valid && !can_issue;
                end else begin
                    state_d = SCB_RUN;
                end
            end
            SCB_FLUSH: begin
                flush = 1'b1;
                if (bus.redirect) begin
                    fcnt_d = FL_LOAD;
                end else if (fcnt_q <= 4'd1) begin
                    fcnt_d  = '0;
                    state_d = SCB_DRAIN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = SCB_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCB_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    scb_counter_bank #(
        .NUM_REGS (NUM_REGS),
        .REG_SEL  (REG_SEL),
        .CNT_W    (CNT_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .inc_en_i  (issue && bus.reg_write_out && bus.rd != '0),
        .inc_sel_i (bus.rd),
        .dec_en_i  (bus.wb_valid && bus.wb_rd != '0),
        .dec_sel_i (bus.wb_rd),
        .cnt_o     (cnt),
        .nz_mask_o (bus.pending_mask)
    );

    assign bus.issue     = issue;
    assign bus.stall     = stall;
    assign bus.flush_id  = flush;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed-vector bench for id_scoreboard_ctrl; expected responses are
// queued by the stimulus and checked by an independent monitor.
module tb_id_scoreboard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_scoreboard_ctrl_if #(.NUM_REGS(32), .REG_SEL(5)) bus ();

    id_scoreboard_ctrl #(
        .NUM_REGS     (32),
        .REG_SEL      (5),
        .CNT_W        (2),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [36:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] m(input int r);
        logic [31:0] x;
        x = 32'd1 << r;
        return x;
    endfunction

    task automatic vec(
        input string      nm,
        input logic       v,
        input logic [4:0] rs1,
        input logic       u1,
        input logic [4:0] rs2,
        input logic       u2,
        input logic [4:0] rd,
        input logic       rw,
        input logic       wbv,
        input logic [4:0] wbrd,
        input logic       redir,
        input logic       e_iss,
        input logic       e_stl,
        input logic       e_fl,
        input logic [1:0] e_st,
        input logic [31:0] e_mask
    );
        exp_t e;
        bus.id_valid      = v;
        bus.rs1           = rs1;
        bus.uses_rs1      = u1;
        bus.rs2           = rs2;
        bus.uses_rs2      = u2;
        bus.rd            = rd;
        bus.reg_write_out = rw;
        bus.wb_valid      = wbv;
        bus.wb_rd         = wbrd;
        bus.redirect      = redir;
        e.name = nm;
        e.v    = {e_iss, e_stl, e_fl, e_st, e_mask};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // monitor: compare whatever the DUT presents mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [36:0] got;
            e   = exp_q.pop_front();
            got = {bus.issue, bus.stall, bus.flush_id,
                   bus.state_dbg, bus.pending_mask};
            n_vec++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s: got iss/stl/fl/st/mask=%b/%b/%b/%0d/%h required %b/%b/%b/%0d/%h",
                         e.name, got[36], got[35], got[34], got[33:32], got[31:0],
                         e.v[36], e.v[35], e.v[34], e.v[33:32], e.v[31:0]);
            end
        end
    end

    localparam logic [1:0] RUN = 2'd0, FL = 2'd1, DR = 2'd2;

    initial begin
        bus.id_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.uses_rs1 = 0;
        bus.uses_rs2 = 0; bus.rd = 0; bus.reg_write_out = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.redirect = 0;
        @(posedge clk); #1;
        vec("reset", 0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, RUN, 0);
        rst = 1'b0;
        vec("nohaz",   1, 29,1, 14,1, 0,0,  0,0, 0, 1,0,0, RUN, 0);
        vec("addi14",  1, 0,1,  0,0,  14,1, 0,0, 0, 1,0,0, RUN, 0);
        vec("add_stl", 1, 1,1,  14,1, 3,1,  0,0, 0, 0,1,0, RUN, m(14));
`ifdef SCB_WB_BYPASS_EN
        vec("wb14_byp",1, 1,1,  14,1, 3,1,  1,14,0, 1,0,0, RUN, m(14));
        vec("idle",    0, 0,0,  0,0,  0,0,  0,0, 0, 0,0,0, RUN, m(3));
`else
        vec("wb14_stl",1, 1,1,  14,1, 3,1,  1,14,0, 0,1,0, RUN, m(14));
        vec("add_go",  1, 1,1,  14,1, 3,1,  0,0, 0, 1,0,0, RUN, 0);
`endif
        vec("wb3",     0, 0,0,  0,0,  0,0,  1,3, 0, 0,0,0, RUN, m(3));
        vec("w24a",    1, 0,0,  0,0,  24,1, 0,0, 0, 1,0,0, RUN, 0);
        vec("w24b",    1, 0,0,  0,0,  24,1, 0,0, 0, 1,0,0, RUN, m(24));
        vec("w24c",    1, 0,0,  0,0,  24,1, 0,0, 0, 1,0,0, RUN, m(24));
        vec("w24d_str",1, 0,0,  0,0,  24,1, 0,0, 0, 0,1,0, RUN, m(24));
        vec("w24e_wb", 1, 0,0,  0,0,  24,1, 1,24,0, 0,1,0, RUN, m(24));
        vec("w24f",    1, 0,0,  0,0,  24,1, 0,0, 0, 1,0,0, RUN, m(24));
        for (int i = 0; i < 3; i++)
            vec("wb24",  0, 0,0,  0,0,  0,0,  1,24,0, 0,0,0, RUN, m(24));
        vec("x0a",     1, 0,1,  0,1,  0,1,  0,0, 0, 1,0,0, RUN, 0);
        vec("x0b",     1, 0,1,  0,1,  0,1,  0,0, 0, 1,0,0, RUN, 0);
        vec("redir",   1, 0,0,  0,0,  0,0,  0,0, 1, 0,0,1, RUN, 0);
        vec("flush",   1, 0,0,  0,0,  0,0,  0,0, 0, 0,0,1, FL,  0);
        vec("drain",   1, 0,0,  0,0,  0,0,  0,0, 0, 0,0,0, DR,  0);
        vec("run",     1, 0,0,  0,0,  0,0,  0,0, 0, 1,0,0, RUN, 0);
        vec("redir2",  1, 0,0,  0,0,  0,0,  0,0, 1, 0,0,1, RUN, 0);
        vec("fl_re",   1, 0,0,  0,0,  0,0,  0,0, 1, 0,0,1, FL,  0);
        vec("fl_ext",  1, 0,0,  0,0,  0,0,  0,0, 0, 0,0,1, FL,  0);
        vec("drain2",  1, 0,0,  0,0,  0,0,  0,0, 0, 0,0,0, DR,  0);
        vec("run2",    1, 0,0,  0,0,  0,0,  0,0, 0, 1,0,0, RUN, 0);
        vec("w15a",    1, 0,0,  0,0,  15,1, 0,0, 0, 1,0,0, RUN, 0);
        vec("w15b",    1, 0,0,  0,0,  15,1, 0,0, 0, 1,0,0, RUN, m(15));
        vec("redir3",  1, 0,0,  0,0,  0,0,  0,0, 1, 0,0,1, RUN, m(15));
        vec("flush3",  0, 0,0,  0,0,  0,0,  0,0, 0, 0,0,1, FL,  m(15));
        rst = 1'b1;
        vec("rst_fl",  0, 0,0,  0,0,  0,0,  0,0, 0, 0,0,0, RUN, 0);
        rst = 1'b0;
        vec("post",    1, 15,1, 0,0,  0,0,  0,0, 0, 1,0,0, RUN, 0);
        vec("idle_end",0, 0,0,  0,0,  0,0,  0,0, 0, 0,0,0, RUN, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d left, required 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
